mc_delay_line: RTL and testbench

MC_DELAY_LINE -- requirements
Module: mc_delay_line

---
 rtl/mc_delay_pkg.sv | 33 +++
 rtl/mc_delay_line_sdp_ram.sv | 32 +++
 rtl/mc_delay_line.sv | 166 ++++++++++++++++
 tb/tb_mc_delay_line.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mc_delay_pkg.sv
// Shared sizing helpers and types for the multi-channel delay line.
package mc_delay_pkg;

  // Delay-index width: clog2 of the per-channel depth, never below 1.
  function automatic int unsigned calc_asize(input int unsigned wdepth);
    return (wdepth > 1) ? $clog2(wdepth) : 1;
  endfunction

  // Channel-index width: max(1, clog2(nch)).
  function automatic int unsigned calc_csize(input int unsigned nch);
    return (nch > 1) ? $clog2(nch) : 1;
  endfunction

  // Flat RAM address width covering nch*wdepth words.
  function automatic int unsigned calc_ram_aw(input int unsigned nch, input int unsigned wdepth);
    return (nch * wdepth > 1) ? $clog2(nch * wdepth) : 1;
  endfunction

  // Largest usable delay for a given depth.
  function automatic int unsigned calc_dmax(input int unsigned wdepth);
    return wdepth - 1;
  endfunction

  localparam int unsigned DSIZE_DEF  = 8;
  localparam int unsigned WDEPTH_DEF = 5;
  localparam int unsigned NCH_DEF    = 2;

  localparam int unsigned RAM_AW = calc_ram_aw(NCH_DEF, WDEPTH_DEF);
  localparam int unsigned DMAX   = calc_dmax(WDEPTH_DEF);

  typedef logic [RAM_AW-1:0] ram_addr_t;

endpackage

// File: rtl/mc_delay_line_sdp_ram.sv
// Simple dual-port sample store: one write port, one registered read port.
// A read and write to the same word in one cycle returns the old contents.
module sdp_ram #(
  parameter int unsigned DW    = 8,
  parameter int unsigned DEPTH = 10,
  parameter int unsigned AW    = 4
) (
  input  logic          clk,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [DW-1:0] wdata_i,
  input  logic          re_i,
  input  logic [AW-1:0] raddr_i,
  output logic [DW-1:0] rdata_o
);

  logic [DW-1:0] mem_q [DEPTH];
  logic [DW-1:0] rdata_q;

  // Write and registered read; non-blocking update gives old-data on collision.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[raddr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/mc_delay_line.sv
// Multi-channel frame delay line: interleaved samples are stored per channel
// and replayed D frames later, with a two-cycle fixed latency.
module mc_delay_line
  import mc_delay_pkg::*;
#(
  parameter  int unsigned DSIZE  = 8,
  parameter  int unsigned WDEPTH = 5,
  parameter  int unsigned NCH    = 2,
  localparam int unsigned ASIZE  = calc_asize(WDEPTH),
  localparam int unsigned CSIZE  = calc_csize(NCH)
) (
  input  logic             clk,
  input  logic             Reset,
  input  logic [DSIZE-1:0] Din,
  input  logic             in_valid,
  input  logic [CSIZE-1:0] in_ch,
  input  logic [ASIZE:0]   Addr,
  output logic [DSIZE-1:0] Q,
  output logic             out_valid,
  output logic [CSIZE-1:0] out_ch,
  output logic             seq_err
);

  localparam int unsigned RAW   = calc_ram_aw(NCH, WDEPTH);
  localparam int unsigned RDEP  = NCH * WDEPTH;
  localparam logic [ASIZE-1:0] DMAX_A   = ASIZE'(calc_dmax(WDEPTH));
  localparam logic [ASIZE:0]   DMAX_W   = {1'b0, DMAX_A};
  localparam logic [CSIZE-1:0] LAST_CH  = CSIZE'(NCH - 1);

  // Control state
  logic [ASIZE-1:0] wptr_q, wptr_d;
  logic [ASIZE-1:0] fill_q, fill_d;
  logic [ASIZE-1:0] dly_q, dly_d;
  logic [CSIZE-1:0] exp_ch_q, exp_ch_d;
  logic             seq_err_q, seq_err_d;

  // Stage 1 (alongside the RAM read)
  logic             v1_q, v1_d;
  logic [CSIZE-1:0] ch1_q, ch1_d;
  logic             byp1_q, byp1_d;
  logic             zero1_q, zero1_d;
  logic [DSIZE-1:0] din1_q, din1_d;

  // Stage 2 (output register)
  logic             out_valid_q, out_valid_d;
  logic [CSIZE-1:0] out_ch_q, out_ch_d;
  logic [DSIZE-1:0] q_q, q_d;

  // Datapath helpers
  logic [ASIZE-1:0] d_clamp, d_cur, rptr;
  logic [RAW-1:0]   base_addr, waddr, raddr;
  logic             frame_end, ram_re;
  logic [DSIZE-1:0] ram_rdata;

  sdp_ram #(
    .DW    (DSIZE),
    .DEPTH (RDEP),
    .AW    (RAW)
  ) u_ram (
    .clk     (clk),
    .we_i    (in_valid),
    .waddr_i (waddr),
    .wdata_i (Din),
    .re_i    (ram_re),
    .raddr_i (raddr),
    .rdata_o (ram_rdata)
  );

  // Next-state: pointers, delay latch, channel tracking and both pipeline stages.
  always_comb begin
    wptr_d      = wptr_q;
    fill_d      = fill_q;
    dly_d       = dly_q;
    exp_ch_d    = exp_ch_q;
    seq_err_d   = seq_err_q;
    v1_d        = in_valid;
    ch1_d       = ch1_q;
    byp1_d      = byp1_q;
    zero1_d     = zero1_q;
    din1_d      = din1_q;
    out_valid_d = v1_q;
    out_ch_d    = out_ch_q;
    q_d         = q_q;

    // A frame's delay is taken from Addr at its channel-0 sample.
    d_clamp   = (Addr > DMAX_W) ? DMAX_A : Addr[ASIZE-1:0];
    d_cur     = (in_ch == '0) ? d_clamp : dly_q;
    rptr      = (wptr_q >= d_cur) ? (wptr_q - d_cur) : (wptr_q + DMAX_A - d_cur + ASIZE'(1));
    base_addr = RAW'(in_ch) * RAW'(WDEPTH);
    waddr     = base_addr + RAW'(wptr_q);
    raddr     = base_addr + RAW'(rptr);
    frame_end = in_valid && (in_ch == LAST_CH);
    ram_re    = in_valid && (d_cur != '0);

    if (in_valid) begin
      exp_ch_d = (in_ch == LAST_CH) ? '0 : in_ch + CSIZE'(1);
      if (in_ch != exp_ch_q) begin
        seq_err_d = 1'b1;
      end
      if (in_ch == '0) begin
        dly_d = d_clamp;
      end
      ch1_d   = in_ch;
      byp1_d  = (d_cur == '0);
      zero1_d = (d_cur > fill_q);
      din1_d  = Din;
    end

    if (frame_end) begin
      wptr_d = (wptr_q == DMAX_A) ? '0 : wptr_q + ASIZE'(1);
      if (fill_q != DMAX_A) begin
        fill_d = fill_q + ASIZE'(1);
      end
    end

    if (v1_q) begin
      out_ch_d = ch1_q;
      if (zero1_q) begin
        q_d = '0;
      end else if (byp1_q) begin
        q_d = din1_q;
      end else begin
        q_d = ram_rdata;
      end
    end
  end

  // State registers with synchronous reset; RAM contents are left untouched.
  always_ff @(posedge clk) begin
    if (Reset) begin
      wptr_q      <= '0;
      fill_q      <= '0;
      dly_q       <= '0;
      exp_ch_q    <= '0;
      seq_err_q   <= 1'b0;
      v1_q        <= 1'b0;
      ch1_q       <= '0;
      byp1_q      <= 1'b0;
      zero1_q     <= 1'b0;
      din1_q      <= '0;
      out_valid_q <= 1'b0;
      out_ch_q    <= '0;
      q_q         <= '0;
    end else begin
      wptr_q      <= wptr_d;
      fill_q      <= fill_d;
      dly_q       <= dly_d;
      exp_ch_q    <= exp_ch_d;
      seq_err_q   <= seq_err_d;
      v1_q        <= v1_d;
      ch1_q       <= ch1_d;
      byp1_q      <= byp1_d;
      zero1_q     <= zero1_d;
      din1_q      <= din1_d;
      out_valid_q <= out_valid_d;
      out_ch_q    <= out_ch_d;
      q_q         <= q_d;
    end
  end

  assign Q         = q_q;
  assign out_valid = out_valid_q;
  assign out_ch    = out_ch_q;
  assign seq_err   = seq_err_q;

endmodule

// File: tb/tb_mc_delay_line.sv
// Directed bench for mc_delay_line at DSIZE=8, WDEPTH=5, NCH=2.
module tb_mc_delay_line;

  logic       clk = 1'b0;
  logic       Reset;
  logic [7:0] Din;
  logic       in_valid;
  logic       in_ch;
  logic [3:0] Addr;
  logic [7:0] Q;
  logic       out_valid;
  logic       out_ch;
  logic       seq_err;

  int errors = 0;
  int checks = 0;

  // Expected output of the sample presented on the previous step.
  logic       pend_v  = 1'b0;
  logic       pend_ch = 1'b0;
  logic [7:0] pend_q  = 8'h00;
  logic [7:0] last_q  = 8'h00;
  logic       exp_seq = 1'b0;

  mc_delay_line #(
    .DSIZE  (8),
    .WDEPTH (5),
    .NCH    (2)
  ) dut (
    .clk       (clk),
    .Reset     (Reset),
    .Din       (Din),
    .in_valid  (in_valid),
    .in_ch     (in_ch),
    .Addr      (Addr),
    .Q         (Q),
    .out_valid (out_valid),
    .out_ch    (out_ch),
    .seq_err   (seq_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock: apply inputs, sample 1 time unit after the edge, and check
  // the output produced by the previous step's sample (two-cycle latency).
  task automatic step(input logic rst, input logic v, input logic ch,
                      input logic [7:0] d, input logic [3:0] a,
                      input logic [7:0] eq, input string tag);
    Reset    = rst;
    in_valid = v;
    in_ch    = ch;
    Din      = d;
    Addr     = a;
    @(posedge clk);
    #1;
    if (rst) begin
      check({tag, " rst out_valid"}, 32'(out_valid), 32'd0);
      check({tag, " rst Q"},         32'(Q),         32'd0);
      check({tag, " rst out_ch"},    32'(out_ch),    32'd0);
      check({tag, " rst seq_err"},   32'(seq_err),   32'd0);
      pend_v  = 1'b0;
      last_q  = 8'h00;
      exp_seq = 1'b0;
    end else begin
      check({tag, " out_valid"}, 32'(out_valid), 32'(pend_v));
      if (pend_v) begin
        check({tag, " out_ch"}, 32'(out_ch), 32'(pend_ch));
        check({tag, " Q"},      32'(Q),      32'(pend_q));
        last_q = pend_q;
      end else begin
        check({tag, " Q hold"}, 32'(Q), 32'(last_q));
      end
      check({tag, " seq_err"}, 32'(seq_err), 32'(exp_seq));
      pend_v  = v;
      pend_ch = ch;
      pend_q  = eq;
    end
  endtask

  task automatic do_reset(input string tag);
    step(1'b1, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, tag);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 1'b0, 8'h00, 4'd0, 8'h00, tag);
  endtask

  // Continuous ramp with a fixed Addr that clamps to D=4: zero for four frames.
  task automatic ramp_d4(input logic [3:0] a, input int nfr, input string tag);
    for (int k = 0; k < nfr; k++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, 1'b1, c[0], 8'(2*k + c), a,
             (k < 4) ? 8'h00 : 8'(2*(k-4) + c), $sformatf("%s k%0d c%0d", tag, k, c));
      end
    end
    idle({tag, " drain"});
  endtask

  initial begin
    Reset = 1'b1; in_valid = 1'b0; in_ch = 1'b0; Din = 8'h00; Addr = 4'd0;

    do_reset("init0");
    do_reset("init1");

    // Addr=4: four frames of zero, then the ramp four frames late.
    ramp_d4(4'd4, 9, "d4");

    // Addr=15 clamps to 4; RAM still holds old data that fill must mask.
    do_reset("r15");
    ramp_d4(4'd15, 9, "d15");

    // Addr 4 -> 1 on the ch1 cycle of frame 6.
    do_reset("rchg");
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, 1'b1, c[0], 8'(2*k + c), 4'd4,
             (k < 4) ? 8'h00 : 8'(2*(k-4) + c), $sformatf("chg k%0d c%0d", k, c));
      end
    end
    step(1'b0, 1'b1, 1'b0, 8'd12, 4'd4, 8'd4,  "chg k6 c0");
    step(1'b0, 1'b1, 1'b1, 8'd13, 4'd1, 8'd5,  "chg k6 c1 old D");
    step(1'b0, 1'b1, 1'b0, 8'd14, 4'd1, 8'd12, "chg k7 c0 D1");
    step(1'b0, 1'b1, 1'b1, 8'd15, 4'd1, 8'd13, "chg k7 c1 D1");
    step(1'b0, 1'b1, 1'b0, 8'd16, 4'd1, 8'd14, "chg k8 c0 D1");
    step(1'b0, 1'b1, 1'b1, 8'd17, 4'd1, 8'd15, "chg k8 c1 D1");
    idle("chg drain");

    // Addr=0 bypass from the first frame, with gaps (Q holds when idle).
    do_reset("rbyp");
    step(1'b0, 1'b1, 1'b0, 8'h11, 4'd0, 8'h11, "byp f0 c0");
    step(1'b0, 1'b1, 1'b1, 8'h12, 4'd0, 8'h12, "byp f0 c1");
    idle("byp gap0");
    idle("byp gap1");
    idle("byp gap2");
    step(1'b0, 1'b1, 1'b0, 8'hA5, 4'd0, 8'hA5, "byp f1 c0");
    idle("byp gap3");
    step(1'b0, 1'b1, 1'b1, 8'h5A, 4'd0, 8'h5A, "byp f1 c1");
    idle("byp drain0");
    idle("byp drain1");

    // Channel order error: ch0, ch0 sets sticky seq_err; ch1 follows in order.
    do_reset("rseq");
    step(1'b0, 1'b1, 1'b0, 8'h10, 4'd0, 8'h10, "seq c0 a");
    exp_seq = 1'b1;
    step(1'b0, 1'b1, 1'b0, 8'h20, 4'd0, 8'h20, "seq c0 b");
    step(1'b0, 1'b1, 1'b1, 8'h21, 4'd0, 8'h21, "seq c1");
    step(1'b0, 1'b1, 1'b0, 8'h22, 4'd0, 8'h22, "seq c0 c");
    step(1'b0, 1'b1, 1'b1, 8'h23, 4'd0, 8'h23, "seq c1 b");
    idle("seq drain0");
    idle("seq drain1");
    do_reset("seq clr");

    // Mid-stream reset with samples in flight, then a fresh stream at once.
    ramp_d4(4'd4, 3, "pre");
    do_reset("rmid0");
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, 1'b1, c[0], 8'(8'h80 + 2*k + c), 4'd4,
             (k < 4) ? 8'h00 : 8'(8'h80 + 2*(k-4) + c), $sformatf("pre2 k%0d c%0d", k, c));
      end
    end
    step(1'b1, 1'b1, 1'b0, 8'hEE, 4'd4, 8'h00, "rmid1");
    for (int k = 0; k < 6; k++) begin
      for (int c = 0; c < 2; c++) begin
        step(1'b0, 1'b1, c[0], 8'(8'h40 + 2*k + c), 4'd4,
             (k < 4) ? 8'h00 : 8'(8'h40 + 2*(k-4) + c), $sformatf("post k%0d c%0d", k, c));
      end
    end
    idle("post drain");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
